// File: rtl/mcbsp_receiver_16bit_s_if.sv
// Receive-side McBSP bus: frame sync, serial data and the word handshake.
interface mcbsp_receiver_16bit_s_if;
   logic        FSR;
   logic        DR;
   logic        rAck;
   logic [15:0] rData;
   logic        rValid;
   logic        busBusy;
   logic        rOverrun;
   logic        frameErr;

   modport master (
      output FSR, DR, rAck,
      input  rData, rValid, busBusy, rOverrun, frameErr
   );

   modport slave (
      input  FSR, DR, rAck,
      output rData, rValid, busBusy, rOverrun, frameErr
   );
endinterface

// File: rtl/mcbsp_receiver_16bit_s.sv
// McBSP 16-bit serial receiver, MSB first, one-word holding register.
// Optional MCBSP_RX_FRAME_ABORT_EN: FSR during a frame restarts it and pulses frameErr.
module mcbsp_receiver_16bit_s (
   input logic                     McBSPClk,
   input logic                     nRst,
   mcbsp_receiver_16bit_s_if.slave bus
);
   typedef enum logic {IDLE, RECV} state_t;

   state_t      state, state_nx;
   logic [3:0]  cnt, cnt_nx;
   logic [15:0] shreg, shreg_nx;
   logic [15:0] data_q, data_nx;
   logic        valid_q, valid_nx;
   logic        busy_q, busy_nx;
   logic        ovr_q, ovr_nx;
   logic        ferr_q, ferr_nx;
   logic [15:0] word;
   logic        abort;

   assign word = {shreg[14:0], bus.DR};

`ifdef MCBSP_RX_FRAME_ABORT_EN
   assign abort = bus.FSR && (cnt != 4'd0);
`else
   assign abort = 1'b0;
`endif

   always_ff @(posedge McBSPClk or negedge nRst) begin
      if (!nRst) begin
         state   <= IDLE;
         cnt     <= 4'd15;
         shreg   <= 16'h0000;
         data_q  <= 16'h0000;
         valid_q <= 1'b0;
         busy_q  <= 1'b0;
         ovr_q   <= 1'b0;
         ferr_q  <= 1'b0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         shreg   <= shreg_nx;
         data_q  <= data_nx;
         valid_q <= valid_nx;
         busy_q  <= busy_nx;
         ovr_q   <= ovr_nx;
         ferr_q  <= ferr_nx;
      end
   end

   always_comb begin
      state_nx = state;
      cnt_nx   = cnt;
      shreg_nx = shreg;
      data_nx  = data_q;
      valid_nx = valid_q;
      busy_nx  = busy_q;
      ovr_nx   = 1'b0;
      ferr_nx  = 1'b0;
      if (valid_q && bus.rAck)
         valid_nx = 1'b0;
      unique case (state)
         IDLE: begin
            if (bus.FSR) begin
               state_nx = RECV;
               cnt_nx   = 4'd15;
               busy_nx  = 1'b1;
            end
         end
         RECV: begin
            if (abort) begin
               shreg_nx = 16'h0000;
               cnt_nx   = 4'd15;
               ferr_nx  = 1'b1;
            end else if (cnt == 4'd0) begin
               // an ack in this same cycle consumes the old word, so no overrun
               shreg_nx = word;
               data_nx  = word;
               valid_nx = 1'b1;
               ovr_nx   = valid_q && !bus.rAck;
               busy_nx  = 1'b0;
               state_nx = IDLE;
            end else begin
               shreg_nx = word;
               cnt_nx   = cnt - 4'd1;
            end
         end
         default: state_nx = IDLE;
      endcase
   end

   assign bus.rData    = data_q;
   assign bus.rValid   = valid_q;
   assign bus.busBusy  = busy_q;
   assign bus.rOverrun = ovr_q;
   assign bus.frameErr = ferr_q;
endmodule

// File: tb/tb_mcbsp_receiver_16bit_s.sv
// Directed bench for mcbsp_receiver_16bit_s; optionally built with
// MCBSP_RX_FRAME_ABORT_EN to exercise frame abort.
module tb_mcbsp_receiver_16bit_s;
   logic McBSPClk = 1'b0;
   logic nRst = 1'b0;
   int   total = 0;
   int   bad = 0;
   int   busy_n, valid_n, ovr_n, ferr_n;
   int   idle_v, idle_b;

   mcbsp_receiver_16bit_s_if bus ();

   mcbsp_receiver_16bit_s dut (
      .McBSPClk (McBSPClk),
      .nRst     (nRst),
      .bus      (bus)
   );

   always #5 McBSPClk = ~McBSPClk;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge McBSPClk);
      #1;
   endtask

   task automatic sample();
      if (bus.busBusy)  busy_n++;
      if (bus.rValid)   valid_n++;
      if (bus.rOverrun) ovr_n++;
      if (bus.frameErr) ferr_n++;
   endtask

   // FSR edge then 16 bit edges; rAck as set by caller applies to the FSR edge
   task automatic frame(input logic [15:0] w, input logic ack_last);
      busy_n = 0; valid_n = 0; ovr_n = 0; ferr_n = 0;
      bus.FSR = 1'b1;
      bus.DR  = 1'b0;
      tick();
      sample();
      bus.FSR  = 1'b0;
      bus.rAck = 1'b0;
      for (int i = 15; i >= 0; i--) begin
         bus.DR = w[i];
         if (i == 0) bus.rAck = ack_last;
         tick();
         sample();
      end
      bus.rAck = 1'b0;
      bus.DR   = 1'b0;
   endtask

   task automatic ack();
      bus.rAck = 1'b1;
      tick();
      bus.rAck = 1'b0;
   endtask

   initial begin
      bus.FSR = 1'b0;
      bus.DR = 1'b0;
      bus.rAck = 1'b0;
      #12;
      check("rst_data", bus.rData, 16'h0000);
      check("rst_flags", {bus.rValid, bus.busBusy, bus.rOverrun, bus.frameErr}, 4'b0000);
      @(posedge McBSPClk);
      #1 nRst = 1'b1;
      tick();

      // basic frame
      frame(16'hA5C3, 1'b0);
      check("a5c3_data", bus.rData, 16'hA5C3);
      check("a5c3_valid", bus.rValid, 1'b1);
      check("a5c3_busy_cnt", busy_n, 16);
      check("a5c3_valid_cnt", valid_n, 1);
      check("a5c3_busy_end", bus.busBusy, 1'b0);

      ack();
      check("ack_clear", bus.rValid, 1'b0);
      check("ack_hold", bus.rData, 16'hA5C3);
      ack();
      check("ack_idle", bus.rValid, 1'b0);

      // back-to-back with acks
      bus.rAck = 1'b1;
      frame(16'h1234, 1'b0);
      check("b2b1_data", bus.rData, 16'h1234);
      check("b2b1_valid_cnt", valid_n, 1);
      check("b2b1_ovr", ovr_n, 0);
      bus.rAck = 1'b1;
      frame(16'hFFFF, 1'b0);
      check("b2b2_data", bus.rData, 16'hFFFF);
      check("b2b2_valid_cnt", valid_n, 1);
      check("b2b2_ovr", ovr_n, 0);
      check("b2b2_busy_cnt", busy_n, 16);

      // overrun
      ack();
      frame(16'h00FF, 1'b0);
      check("ovr1_data", bus.rData, 16'h00FF);
      check("ovr1_ovr", ovr_n, 0);
      frame(16'h8001, 1'b0);
      check("ovr2_data", bus.rData, 16'h8001);
      check("ovr2_valid", bus.rValid, 1'b1);
      check("ovr2_pulse_now", bus.rOverrun, 1'b1);
      check("ovr2_ovr_cnt", ovr_n, 1);
      tick();
      check("ovr2_pulse_gone", bus.rOverrun, 1'b0);
      frame(16'h1111, 1'b1);
      check("ovr3_data", bus.rData, 16'h1111);
      check("ovr3_valid", bus.rValid, 1'b1);
      check("ovr3_ovr", ovr_n, 0);

      // reset mid-frame
      ack();
      begin
         logic [15:0] w;
         w = 16'hBEEF;
         bus.FSR = 1'b1;
         tick();
         bus.FSR = 1'b0;
         for (int i = 15; i >= 8; i--) begin
            bus.DR = w[i];
            tick();
         end
         check("mid_busy", bus.busBusy, 1'b1);
         nRst = 1'b0;
         #1;
         check("mid_rst_data", bus.rData, 16'h0000);
         check("mid_rst_flags",
               {bus.rValid, bus.busBusy, bus.rOverrun, bus.frameErr}, 4'b0000);
         tick();
         nRst = 1'b1;
         idle_v = 0; idle_b = 0;
         for (int i = 7; i >= 0; i--) begin
            bus.DR = w[i];
            tick();
            if (bus.rValid) idle_v++;
            if (bus.busBusy) idle_b++;
         end
         bus.DR = 1'b0;
         check("post_rst_valid", idle_v, 0);
         check("post_rst_busy", idle_b, 0);
      end
      frame(16'h0F0F, 1'b0);
      check("post_rst_data", bus.rData, 16'h0F0F);
      check("post_rst_vcnt", valid_n, 1);

      // FSR re-asserted after 5 bits
      ack();
      bus.FSR = 1'b1;
      tick();
      bus.FSR = 1'b0;
      for (int i = 0; i < 5; i++) begin
         bus.DR = 1'b1;
         tick();
      end
      frame(16'h5A5A, 1'b0);
`ifdef MCBSP_RX_FRAME_ABORT_EN
      check("abort_data", bus.rData, 16'h5A5A);
      check("abort_ferr", ferr_n, 1);
      check("abort_valid_cnt", valid_n, 1);
      check("abort_busy_cnt", busy_n, 16);
`else
      check("noabort_data", bus.rData, 16'hF969);
      check("noabort_ferr", ferr_n, 0);
      check("noabort_valid_cnt", valid_n, 7);
      check("noabort_busy_cnt", busy_n, 10);
`endif
      check("final_valid", bus.rValid, 1'b1);
      check("final_busy", bus.busBusy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/mcbsp_receiver_16bit_s.md
MCBSP_RECEIVER_16BIT_S -- requirements
Module: mcbsp_receiver_16bit_s

Interface
REQ-001 The block SHALL have a port McBSPClk, input, 1 bit: the single clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have a port nRst, input, 1 bit: asynchronous, active-low reset.
REQ-003 The block SHALL have a port FSR, input, 1 bit: frame sync from the transmitter's FSX, high for one clock before the first data bit.
REQ-004 The block SHALL have a port DR, input, 1 bit: serial data from the transmitter's DX, MSB first.
REQ-005 The block SHALL have a port rAck, input, 1 bit: consumer acknowledge of rData.
REQ-006 The block SHALL have a port rData, output, 16 bits: last completed received word.
REQ-007 The block SHALL have a port rValid, output, 1 bit: rData holds an unacknowledged word.
REQ-008 The block SHALL have a port busBusy, output, 1 bit: high while a frame is being shifted in.
REQ-009 The block SHALL have a port rOverrun, output, 1 bit: one-cycle pulse when an unacknowledged word is overwritten.
REQ-010 The block SHALL have a port frameErr, output, 1 bit: one-cycle pulse when a frame is aborted (REQ-029).

Function
REQ-011 The state machine SHALL have exactly two states: IDLE and RECV.
REQ-012 In IDLE, FSR sampled high at rising edge N SHALL move the block to RECV, load the bit counter with 15 and set busBusy at edge N.
REQ-013 In IDLE, FSR sampled low SHALL keep the block in IDLE, and DR SHALL be ignored.
REQ-014 In RECV, at edges N+1 through N+16, DR SHALL be shifted into a 16-bit shift register, with the first sampled bit ending in bit 15 and the last sampled bit in bit 0.
REQ-015 The bit counter SHALL decrement by 1 per RECV edge and SHALL never wrap below 0.
REQ-016 At edge N+16, when the counter is 0, the block SHALL load rData with the full assembled word, set rValid, clear busBusy and return to IDLE.
REQ-017 Latency from the FSR-high sample to rValid high SHALL be exactly 16 clocks.
REQ-018 The FSR-high edge to the next FSR-high edge SHALL be at least 17 clocks, and the block SHALL accept back-to-back frames with FSR sampled high at edge N+17.
REQ-019 rValid SHALL stay high until rAck is sampled high while rValid is 1; rValid SHALL clear at that edge, and rData SHALL hold its value.
REQ-020 rAck sampled while rValid is 0 SHALL have no effect.
REQ-021 If a word completes while rValid is 1 and rAck is low, rData SHALL be overwritten with the new word, rValid SHALL stay 1, and rOverrun SHALL pulse high for one clock.
REQ-022 If a word completes in the same cycle rAck is high, the new word SHALL load, rValid SHALL stay 1, and rOverrun SHALL stay 0.
REQ-023 rOverrun and frameErr SHALL default low every cycle except the cycle they pulse.
REQ-024 rData SHALL change only at word completion (or at reset).
REQ-025 Without REQ-029 compiled in, FSR in RECV SHALL be ignored.

Reset
REQ-026 Asserting nRst low SHALL, asynchronously, force state IDLE, counter 15, shift register 0x0000, rData 0x0000, and rValid, busBusy, rOverrun and frameErr to 0.
REQ-027 Reset asserted mid-frame SHALL discard the partial word, and no rValid SHALL follow.
REQ-028 After release, the first frame SHALL be recognised only from a fresh FSR-high sample.

Configuration
REQ-029 With macro MCBSP_RX_FRAME_ABORT_EN defined, FSR sampled high in RECV while the counter is nonzero SHALL discard the partial word, pulse frameErr for one clock, reload the counter with 15 and remain in RECV, treating that edge as a new frame's N.
REQ-030 Without MCBSP_RX_FRAME_ABORT_EN, REQ-025 SHALL apply and frameErr SHALL be tied to 0.

Verification
REQ-031 The bench SHALL cover: FSR pulse, then DR bits 1010_0101_1100_0011 -> rValid rises 16 clocks later, rData=0xA5C3, busBusy high for 16 clocks.
REQ-032 The bench SHALL cover: back-to-back frames 0x1234 then 0xFFFF with FSR at edge N+17 and rAck after each word -> two rValid events with the correct words and rOverrun=0.
REQ-033 The bench SHALL cover: frame 0x00FF unacknowledged, then frame 0x8001 -> rData=0x8001, rValid=1, rOverrun pulses one cycle; rAck in the completion cycle -> no pulse.
REQ-034 The bench SHALL cover: nRst low at bit 7 of frame 0xBEEF -> all outputs 0 immediately; no rValid; next frame 0x0F0F is received correctly.
REQ-035 The bench SHALL cover: with MCBSP_RX_FRAME_ABORT_EN, FSR re-asserted after 5 bits, then a full 0x5A5A frame -> frameErr pulses once and rData=0x5A5A 16 clocks after the second FSR.
REQ-036 The bench SHALL cover: without MCBSP_RX_FRAME_ABORT_EN, the same stimulus -> the word completes at the original count, frameErr stays 0.
